// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, load/ALU result select, and retired counter.
// Optional same-cycle register-file read bypass is enabled by defining WB_BYPASS_EN.
module wb_stage #(
    parameter int WORD   = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              mem_valid,
    input  logic              WB_EN_in,
    input  logic              MEM_R_EN_in,
    input  logic [REG_AW-1:0] dest_in,
    input  logic [WORD-1:0]   ALU_result_in,
    input  logic [WORD-1:0]   mem_data_in,
`ifdef WB_BYPASS_EN
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic [WORD-1:0]   rf_val1,
    input  logic [WORD-1:0]   rf_val2,
    output logic [WORD-1:0]   val1,
    output logic [WORD-1:0]   val2,
`endif
    output logic              WB_EN,
    output logic [REG_AW-1:0] destWB,
    output logic [WORD-1:0]   valueWB,
    output logic [31:0]       retired
);

    logic              valid_q;
    logic              wb_q;
    logic              memr_q;
    logic [REG_AW-1:0] dest_q;
    logic [WORD-1:0]   alu_q;
    logic [WORD-1:0]   mem_q;
    logic [31:0]       retired_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            wb_q      <= 1'b0;
            memr_q    <= 1'b0;
            dest_q    <= '0;
            alu_q     <= '0;
            mem_q     <= '0;
            retired_q <= '0;
        end else if (!freeze) begin
            valid_q   <= mem_valid;
            wb_q      <= WB_EN_in;
            memr_q    <= MEM_R_EN_in;
            dest_q    <= dest_in;
            alu_q     <= ALU_result_in;
            mem_q     <= mem_data_in;
            // The instruction held before this edge is the one leaving WB.
            if (valid_q)
                retired_q <= retired_q + 32'd1;
        end
    end

    always_comb begin
        WB_EN   = valid_q & wb_q;
        destWB  = dest_q;
        valueWB = memr_q ? mem_q : alu_q;
        retired = retired_q;
    end

`ifdef WB_BYPASS_EN
    always_comb begin
        val1 = (WB_EN && (destWB == src1)) ? valueWB : rf_val1;
        val2 = (WB_EN && (destWB == src2)) ? valueWB : rf_val2;
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage; bypass checks compile in when WB_BYPASS_EN is defined.
`timescale 1ns/1ps
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        mem_valid;
    logic        WB_EN_in;
    logic        MEM_R_EN_in;
    logic [3:0]  dest_in;
    logic [31:0] ALU_result_in;
    logic [31:0] mem_data_in;
    logic        WB_EN;
    logic [3:0]  destWB;
    logic [31:0] valueWB;
    logic [31:0] retired;
`ifdef WB_BYPASS_EN
    logic [3:0]  src1, src2;
    logic [31:0] rf_val1, rf_val2, val1, val2;
`endif

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    wb_stage #(.WORD(32), .REG_AW(4)) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .mem_valid(mem_valid),
        .WB_EN_in(WB_EN_in),
        .MEM_R_EN_in(MEM_R_EN_in),
        .dest_in(dest_in),
        .ALU_result_in(ALU_result_in),
        .mem_data_in(mem_data_in),
`ifdef WB_BYPASS_EN
        .src1(src1),
        .src2(src2),
        .rf_val1(rf_val1),
        .rf_val2(rf_val2),
        .val1(val1),
        .val2(val2),
`endif
        .WB_EN(WB_EN),
        .destWB(destWB),
        .valueWB(valueWB),
        .retired(retired)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic en, input logic [3:0] d,
                             input logic [31:0] v, input logic [31:0] r);
        check({tag, ".WB_EN"},   {63'd0, WB_EN}, {63'd0, en});
        check({tag, ".destWB"},  {60'd0, destWB}, {60'd0, d});
        check({tag, ".valueWB"}, {32'd0, valueWB}, {32'd0, v});
        check({tag, ".retired"}, {32'd0, retired}, {32'd0, r});
    endtask

    task automatic drive(input logic v, input logic we, input logic ld, input logic [3:0] d,
                         input logic [31:0] alu, input logic [31:0] md);
        mem_valid     = v;
        WB_EN_in      = we;
        MEM_R_EN_in   = ld;
        dest_in       = d;
        ALU_result_in = alu;
        mem_data_in   = md;
    endtask

    initial begin
        rst    = 1'b1;
        freeze = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h55, 32'h66);
`ifdef WB_BYPASS_EN
        src1 = 4'd0; src2 = 4'd0; rf_val1 = 32'h0; rf_val2 = 32'h0;
`endif
        tick();
        tick();
        check_out("reset", 1'b0, 4'd0, 32'h0, 32'h0);
`ifdef WB_BYPASS_EN
        rf_val1 = 32'h11; rf_val2 = 32'h22;
        #1;
        check("reset.val1", {32'd0, val1}, 64'h11);
        check("reset.val2", {32'd0, val2}, 64'h22);
`endif

        // ALU writeback
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 4'd1, 32'h2, 32'h99);
        tick();
        check_out("alu", 1'b1, 4'd1, 32'h2, 32'h0);

        // Load writeback
        drive(1'b1, 1'b1, 1'b1, 4'd2, 32'h100, 32'h4);
        tick();
        check_out("load", 1'b1, 4'd2, 32'h4, 32'h1);
`ifdef WB_BYPASS_EN
        src1 = 4'd2; rf_val1 = 32'h0; src2 = 4'd1; rf_val2 = 32'h2;
        #1;
        check("byp.val1", {32'd0, val1}, 64'h4);
        check("byp.val2", {32'd0, val2}, 64'h2);
`endif

        // Bubble with WB_EN_in high
        mem_valid = 1'b0;
        tick();
        check_out("bubble", 1'b0, 4'd2, 32'h4, 32'h2);
`ifdef WB_BYPASS_EN
        check("byp_off.val1", {32'd0, val1}, 64'h0);
`endif
        tick();
        check_out("bubble2", 1'b0, 4'd2, 32'h4, 32'h2);

        // Freeze
        drive(1'b1, 1'b1, 1'b0, 4'd3, 32'h7, 32'h0);
        tick();
        check_out("pre_frz", 1'b1, 4'd3, 32'h7, 32'h2);
        freeze = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd4, 32'h8, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("frozen", 1'b1, 4'd3, 32'h7, 32'h2);
        end
        freeze = 1'b0;
        tick();
        check_out("unfrz", 1'b1, 4'd4, 32'h8, 32'h3);

        // Back-to-back writes to the same register
        drive(1'b1, 1'b1, 1'b0, 4'd6, 32'hA, 32'h0);
        tick();
        check_out("b2b_a", 1'b1, 4'd6, 32'hA, 32'h4);
        drive(1'b1, 1'b1, 1'b0, 4'd6, 32'hB, 32'h0);
        tick();
        check_out("b2b_b", 1'b1, 4'd6, 32'hB, 32'h5);

        // Counter wrap from a forced preload
        drive(1'b1, 1'b1, 1'b0, 4'd5, 32'h9, 32'h0);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        #1;
        check("preload", {32'd0, retired}, 64'hFFFF_FFFF);
        tick();
        check_out("wrap", 1'b1, 4'd5, 32'h9, 32'h0);

        // Reset while frozen with a valid instruction held
        freeze = 1'b1;
        rst    = 1'b1;
        tick();
        check_out("midrst", 1'b0, 4'd0, 32'h0, 32'h0);
        rst    = 1'b0;
        freeze = 1'b0;
        mem_valid = 1'b0;
        tick();
        check_out("postrst", 1'b0, 4'd5, 32'h9, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the ARM pipeline: holds the MEM/WB pipeline register, selects the load data or the ALU result, and drives the register file's write port (`WB_EN`, `destWB`, `valueWB`). It sits directly upstream of the register file and downstream of the MEM stage. It honours the memory-stall freeze, counts retired instructions, and can optionally bypass same-cycle register-file reads.

## Interface
Parameters:
- `WORD`, 32: data width.
- `REG_AW`, 4: register address width (16 registers).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `freeze`  in  1  MEM-stage stall; pipeline register and counter hold.
- `mem_valid`  in  1  MEM stage presents a real instruction (0 = bubble).
- `WB_EN_in`  in  1  instruction writes a register.
- `MEM_R_EN_in`  in  1  instruction is a load; write memory data.
- `dest_in`  in  `REG_AW`  destination register.
- `ALU_result_in`  in  `WORD`  ALU result from MEM stage.
- `mem_data_in`  in  `WORD`  load data from data memory.
- `WB_EN`  out  1  register-file write enable.
- `destWB`  out  `REG_AW`  register-file write address.
- `valueWB`  out  `WORD`  register-file write data.
- `retired`  out  32  count of instructions leaving WB.
- Only with `WB_BYPASS_EN`: `src1`, `src2` in `REG_AW`; `rf_val1`, `rf_val2` in `WORD` (raw register-file read data); `val1`, `val2` out `WORD` (bypassed read data).

## Operation
- Pipeline register fields: `valid_q`, `wb_q`, `memr_q`, `dest_q`, `alu_q`, `mem_q`.
- At each rising edge, priority order:
  1. `rst`: all fields cleared to 0; `retired` cleared to 0.
  2. `freeze`: all fields and `retired` hold.
  3. Otherwise: `valid_q`←`mem_valid`, `wb_q`←`WB_EN_in`, `memr_q`←`MEM_R_EN_in`, `dest_q`←`dest_in`, `alu_q`←`ALU_result_in`, `mem_q`←`mem_data_in`.
- `retired` increments by 1 at each non-reset, non-frozen edge where `valid_q`=1 before the edge (the instruction leaves WB).
  - Counts every valid instruction, including stores and branches with `wb_q`=0.
  - Wraps from 0xFFFFFFFF to 0.
- Outputs are combinational from the register:
  - `WB_EN` = `valid_q & wb_q`.
  - `destWB` = `dest_q`.
  - `valueWB` = `memr_q ? mem_q : alu_q`.
- Bubbles (`mem_valid`=0) never assert `WB_EN`, whatever `WB_EN_in` is.
- During `freeze`, `WB_EN` stays as captured. The register file rewrites the same value each frozen cycle, which is harmless and required.
- No state machine beyond the pipeline register and the counter.

## Timing
- Latency: MEM-stage inputs present at edge N appear on `WB_EN`/`destWB`/`valueWB` after edge N. The register file commits them at edge N+1.
- Reset values after a reset edge: `WB_EN`=0, `destWB`=0, `valueWB`=0, `retired`=0. With the macro, `val1`/`val2` equal `rf_val1`/`rf_val2`.
- Reset mid-operation:
  - A held instruction is discarded without retiring.
  - `WB_EN` drops immediately after the reset edge.
  - Reset overrides `freeze`.
- Freeze released: the next edge captures the MEM inputs present on that edge. No instruction is duplicated or lost.
- Back-to-back writes to the same register each produce one write, one cycle apart.

## Configuration
- `WB_BYPASS_EN` defined:
  - `val1` = (`WB_EN` && `destWB`==`src1`) ? `valueWB` : `rf_val1`. `val2` works the same way with `src2`/`rf_val2`.
  - Purely combinational: a read in the same cycle as a write returns the new value.
  - Bypass applies to every register, including R0.
- `WB_BYPASS_EN` undefined: the `src1`, `src2`, `rf_val1`, `rf_val2`, `val1`, `val2` ports and the bypass logic do not exist. The ID stage relies on hazard stalls instead.

## Test plan
- Reset: hold `rst`=1 for 2 edges with `mem_valid`=1, `WB_EN_in`=1 -> `WB_EN`=0, `destWB`=0, `valueWB`=0, `retired`=0.
- ALU writeback: `mem_valid`=1, `WB_EN_in`=1, `MEM_R_EN_in`=0, `dest_in`=1, `ALU_result_in`=0x2, `mem_data_in`=0x99 -> after one edge `WB_EN`=1, `destWB`=1, `valueWB`=0x2. One edge later `retired`=1.
- Load writeback, then bubble: `MEM_R_EN_in`=1, `dest_in`=2, `mem_data_in`=0x4, `ALU_result_in`=0x100 -> `valueWB`=0x4. Next cycle `mem_valid`=0 with `WB_EN_in`=1 -> `WB_EN`=0, and `retired` does not count the bubble.
- Freeze: capture a write to R3 value 0x7, then assert `freeze` for 3 edges while inputs change to R4/0x8 -> outputs stay R3/0x7 and `retired` is unchanged. Release `freeze` -> R4/0x8 appears after the next edge.
- Counter wrap and mid-reset: preload to 0xFFFFFFFF (via 2^32−1 retirements or a forced value) and retire one more -> `retired`=0. Assert `rst` while frozen with `valid_q`=1 -> all outputs 0 after that edge.
- With `WB_BYPASS_EN`: `WB_EN`=1, `destWB`=2, `valueWB`=0x4, `src1`=2, `rf_val1`=0x0, `src2`=1, `rf_val2`=0x2 -> `val1`=0x4, `val2`=0x2. Drop `WB_EN` -> `val1`=0x0.
